// File: rtl/rom_w_ctrl_if.sv
// Stream/command interface between the weight-ROM controller and its users.
// master: the controller (consumes commands and out_ready, drives the stream).
// slave:  the command source / MAC-array side.
interface rom_w_ctrl_if #(
    parameter int N_LEN = 16
) ();
    // Command side
    logic             start;
    logic [1:0]       layer_sel;
    logic [7:0]       rep_num;

    // Stream side
    logic             out_ready;
    logic [N_LEN-1:0] rom_addr;
    logic             w_valid;
    logic             w_last;
    logic [N_LEN-1:0] w_idx;

    // Status
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, layer_sel, rep_num, out_ready,
        output rom_addr, w_valid, w_last, w_idx, busy, done, err
    );

    modport slave (
        output start, layer_sel, rep_num, out_ready,
        input  rom_addr, w_valid, w_last, w_idx, busy, done, err
    );
endinterface

// File: rtl/rom_w_ctrl.sv
// Address sequencer / stream controller for the mix-layer weight ROM.
// Walks one selected HID_DIM x HID_DIM matrix (WORDS packed words) and
// re-streams it a requested number of times. The ROM has a 1-cycle registered
// read, so rom_addr is steered one cycle ahead: the data seen while STREAM
// presents word ptr is always mem[base+ptr], and stays put under backpressure.
module rom_w_ctrl #(
    parameter int HID_DIM = 24,
    parameter int DATA_N  = 8,
    parameter int N_LEN   = 16
) (
    input  logic         clk,
    input  logic         rst,
    rom_w_ctrl_if.master bus
);
    // Words per matrix; derived, not a parameter.
    localparam int               WORDS    = HID_DIM * HID_DIM / DATA_N;
    localparam logic [N_LEN-1:0] WORDS_N  = N_LEN'(WORDS);
    localparam logic [N_LEN-1:0] LAST_PTR = N_LEN'(WORDS - 1);

    // All three matrices must be addressable with N_LEN bits.
    if (64'(3 * WORDS) > (64'd1 << N_LEN)) begin : g_addr_range_chk
        $error("rom_w_ctrl: 3*WORDS does not fit in N_LEN address bits");
    end
    if ((HID_DIM * HID_DIM) % DATA_N != 0) begin : g_pack_chk
        $error("rom_w_ctrl: HID_DIM*HID_DIM must be a multiple of DATA_N");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [N_LEN-1:0] base_q,    base_d;
    logic [7:0]       target_q,  target_d;
    logic [7:0]       rep_q,     rep_d;
    logic [N_LEN-1:0] ptr_q,     ptr_d;
    logic             w_valid_q, w_valid_d;
    logic             w_last_q,  w_last_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    logic             accept;
    logic             at_last;
    logic             more_pass;
    logic [N_LEN-1:0] sel_base;
    logic [N_LEN-1:0] ptr_inc;
    logic [N_LEN-1:0] rom_addr_c;

    // Handshake and pass-progress decodes shared by FSM and address steering.
    always_comb begin
        accept    = w_valid_q & bus.out_ready;
        at_last   = (ptr_q == LAST_PTR);
        more_pass = ({1'b0, rep_q} + 9'd1) < {1'b0, target_q};
        sel_base  = N_LEN'(bus.layer_sel) * WORDS_N;
        ptr_inc   = ptr_q + N_LEN'(1);
    end

    // FSM next state, pass/word counters and registered stream/status outputs.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        base_d   = base_q;
        target_d = target_q;
        rep_d    = rep_q;
        ptr_d    = ptr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.layer_sel == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        base_d   = sel_base;
                        target_d = (bus.rep_num == 8'd0) ? 8'd1 : bus.rep_num;
                        rep_d    = 8'd0;
                        ptr_d    = '0;
                        state_d  = S_PRIME;
                    end
                end
            end

            // One cycle to let the ROM fetch the first word at base.
            S_PRIME: begin
                state_d = S_STREAM;
            end

            S_STREAM: begin
                if (accept) begin
                    if (!at_last) begin
                        ptr_d = ptr_inc;
                    end else if (more_pass) begin
                        ptr_d = '0;
                        rep_d = rep_q + 8'd1;
                    end else begin
                        ptr_d   = '0;
                        rep_d   = 8'd0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        w_valid_d = (state_d == S_STREAM);
        w_last_d  = (state_d == S_STREAM) && (ptr_d == LAST_PTR);
        busy_d    = (state_d != S_IDLE);
    end

    // ROM address steering: one word ahead of the presented word when it is
    // being accepted, otherwise re-read the presented word to hold the data.
    always_comb begin
        rom_addr_c = '0;
        case (state_q)
            S_PRIME: begin
                rom_addr_c = base_q;
            end
            S_STREAM: begin
                if (accept && !at_last) begin
                    rom_addr_c = base_q + ptr_inc;
                end else if (accept) begin
                    // Wrap for the next pass; on the final pass this value is
                    // unused but base keeps it inside the ROM.
                    rom_addr_c = base_q;
                end else begin
                    rom_addr_c = base_q + ptr_q;
                end
            end
            default: begin
                rom_addr_c = '0;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            target_q  <= 8'd1;
            rep_q     <= 8'd0;
            ptr_q     <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            target_q  <= target_d;
            rep_q     <= rep_d;
            ptr_q     <= ptr_d;
            w_valid_q <= w_valid_d;
            w_last_q  <= w_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.rom_addr = rom_addr_c;
    assign bus.w_valid  = w_valid_q;
    assign bus.w_last   = w_last_q;
    assign bus.w_idx    = ptr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_rom_w_ctrl.sv
// Self-checking bench for rom_w_ctrl: a behavioural ROM with a registered read
// sits on rom_addr; stimulus pushes the expected word sequence into a queue and
// a monitor pops and compares each accepted word.
module tb_rom_w_ctrl;
    localparam int N_LEN      = 16;
    localparam int WORDS      = 72;   // 24*24/8
    localparam int ADDR_LIMIT = 216;  // 3*WORDS

    typedef struct {
        int idx;
        int addr;
        bit last;
        bit fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_w_ctrl_if #(.N_LEN(N_LEN)) bus ();

    rom_w_ctrl #(
        .HID_DIM(24),
        .DATA_N (8),
        .N_LEN  (N_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   accepts = 0;
    exp_t sb[$];
    bit   rand_ready = 1'b0;

    // ROM content: address-dependent hash so every word is distinct.
    function automatic logic [15:0] rom_f(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'hA5C3;
    endfunction

    // Registered-read ROM model.
    logic [15:0] rom_data;
    always @(posedge clk) rom_data <= rom_f(bus.rom_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Expected stream for one job: target passes over matrix sel.
    task automatic push_job(input int sel, input int target);
        for (int r = 0; r < target; r++) begin
            for (int i = 0; i < WORDS; i++) begin
                sb.push_back('{idx: i, addr: sel * WORDS + i, last: (i == WORDS - 1),
                               fin: (r == target - 1) && (i == WORDS - 1)});
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    bit          prev_stall = 1'b0;
    bit          exp_done   = 1'b0;
    logic [15:0] prev_idx;
    logic [15:0] prev_data;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            if (bus.done || exp_done) check("done_pulse", bus.done, exp_done);
            exp_done = 1'b0;
            check("addr_range", bus.rom_addr < ADDR_LIMIT, 1);
            if (prev_stall && bus.w_valid) begin
                check("hold_idx", bus.w_idx, prev_idx);
                check("hold_data", rom_data, prev_data);
            end
            if (bus.w_valid && bus.out_ready) begin
                accepts++;
                if (sb.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    e = sb.pop_front();
                    check("word_idx", bus.w_idx, e.idx);
                    check("word_last", bus.w_last, e.last);
                    check("word_data", rom_data, rom_f(16'(e.addr)));
                    exp_done = e.fin;
                end
            end
            prev_stall = bus.w_valid && !bus.out_ready;
            prev_idx   = bus.w_idx;
            prev_data  = rom_data;
        end
    end

    // Pseudo-random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Pulse start for one cycle; returns 1 time unit after the capturing edge.
    task automatic pulse_start(input int sel, input int rep);
        bus.start     = 1'b1;
        bus.layer_sel = 2'(sel);
        bus.rep_num   = 8'(rep);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Accepted start: PRIME after one edge, first valid word after the second.
    task automatic start_checked(input int sel, input int rep, input int base);
        pulse_start(sel, rep);
        check("prime_valid", bus.w_valid, 0);
        check("prime_busy", bus.busy, 1);
        check("prime_addr", bus.rom_addr, base);
        @(posedge clk); #1;
        check("first_valid", bus.w_valid, 1);
        check("first_idx", bus.w_idx, 0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) fail_now(name);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic wait_word(input int idx, input int budget, input string name);
        int n = 0;
        while (!(bus.w_valid && bus.w_idx == 16'(idx)) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) fail_now(name);
    endtask

    initial begin
        int a0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.layer_sel = 2'd0;
        bus.rep_num   = 8'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.w_valid, 0);
        check("rst_last", bus.w_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_idx", bus.w_idx, 0);
        check("rst_addr", bus.rom_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // W_1, one pass, no backpressure
        bus.out_ready = 1'b1;
        a0 = accepts;
        push_job(0, 1);
        start_checked(0, 1, 0);
        wait_idle(400, "t1_timeout");
        check("t1_count", accepts - a0, 72);

        // W_3, three passes back to back
        a0 = accepts;
        push_job(2, 3);
        start_checked(2, 3, 144);
        wait_idle(800, "t2_timeout");
        check("t2_count", accepts - a0, 216);

        // W_2 under random backpressure
        a0 = accepts;
        push_job(1, 1);
        start_checked(1, 1, 72);
        rand_ready = 1'b1;
        wait_idle(3000, "t3_timeout");
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        check("t3_count", accepts - a0, 72);

        // Illegal layer select
        pulse_start(3, 1);
        check("err_pulse", bus.err, 1);
        check("err_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("err_clear", bus.err, 0);
        check("err_valid", bus.w_valid, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("err_idle_valid", bus.w_valid, 0);

        // Start while busy is ignored
        a0 = accepts;
        push_job(0, 1);
        start_checked(0, 1, 0);
        wait_word(10, 200, "t5_wait");
        pulse_start(2, 5);
        check("busy_start_err", bus.err, 0);
        check("busy_start_busy", bus.busy, 1);
        wait_idle(400, "t5_timeout");
        check("t5_count", accepts - a0, 72);

        // Reset mid-stream, then a fresh start
        push_job(1, 2);
        start_checked(1, 2, 72);
        wait_word(40, 200, "t6_wait");
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", bus.w_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_addr", bus.rom_addr, 0);
        check("mid_rst_idx", bus.w_idx, 0);
        sb.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        a0 = accepts;
        push_job(1, 1);
        start_checked(1, 1, 72);
        wait_idle(400, "t6_timeout");
        check("t6_count", accepts - a0, 72);

        // rep_num = 0 behaves as one pass
        a0 = accepts;
        push_job(0, 1);
        start_checked(0, 0, 0);
        wait_idle(400, "t7_timeout");
        check("t7_count", accepts - a0, 72);
        check("t7_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
